// File: rtl/sram_arbiter.sv
// Merges the CPU instruction-fetch and data ports onto one single-port synchronous SRAM.
// Data wins ties, but a saturating starvation counter periodically forces an instruction grant.
module sram_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] cpu_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic               inst_grant_s;
    logic               data_grant_s;
    logic               starved_s;
    logic [3:0]         starve_cnt_r;
    logic [3:0]         starve_nxt_s;
    logic [MEM_LAT-1:0] pipe_vld_r;
    logic [MEM_LAT-1:0] pipe_dat_r;

    // Grant selection; reset suppresses every grant so nothing reaches the SRAM.
    always_comb begin
        starved_s = inst_req & (starve_cnt_r == STARVE_LIM);
        if (rst) begin
            inst_grant_s = 1'b0;
            data_grant_s = 1'b0;
        end else if (data_req && !starved_s) begin
            inst_grant_s = 1'b0;
            data_grant_s = 1'b1;
        end else if (inst_req) begin
            inst_grant_s = 1'b1;
            data_grant_s = 1'b0;
        end else begin
            inst_grant_s = 1'b0;
            data_grant_s = 1'b0;
        end
    end

    assign inst_addr_ok = inst_grant_s;
    assign data_addr_ok = data_grant_s;
    assign mem_en       = inst_grant_s | data_grant_s;
    assign mem_wdata    = data_wdata;
    assign cpu_rdata    = mem_rdata;

    // SRAM address and byte enables follow the granted port; fetches never write.
    always_comb begin
        if (data_grant_s) begin
            mem_addr = data_addr;
        end else begin
            mem_addr = inst_addr;
        end
        if (data_grant_s && data_wr) begin
            mem_we = data_wstrb;
        end else begin
            mem_we = 4'b0000;
        end
    end

    // Starvation counter next state: counts data grants that bypass a waiting fetch.
    always_comb begin
        if (inst_grant_s || !inst_req) begin
            starve_nxt_s = 4'd0;
        end else if (data_grant_s && (starve_cnt_r < STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + 4'd1;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Response pipe: one {valid, is_data} stage per cycle of SRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_r <= '0;
            pipe_dat_r <= '0;
        end else begin
            pipe_vld_r[0] <= mem_en;
            pipe_dat_r[0] <= data_grant_s;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_dat_r[i] <= pipe_dat_r[i-1];
            end
        end
    end

    assign inst_data_ok = ~rst & pipe_vld_r[MEM_LAT-1] & ~pipe_dat_r[MEM_LAT-1];
    assign data_data_ok = ~rst & pipe_vld_r[MEM_LAT-1] &  pipe_dat_r[MEM_LAT-1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a MEM_LAT=1 instance with a byte-writable SRAM
// model and a MEM_LAT=3 instance with an address-derived read pipeline.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT=1 instance signals
    logic        rst1, inst_req1, inst_addr_ok1, inst_data_ok1;
    logic        data_req1, data_wr1, data_addr_ok1, data_data_ok1, mem_en1;
    logic [3:0]  data_wstrb1, mem_we1;
    logic [31:0] inst_addr1, data_addr1, data_wdata1, cpu_rdata1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    // MEM_LAT=3 instance signals
    logic        rst3, inst_req3, inst_addr_ok3, inst_data_ok3;
    logic        data_req3, data_wr3, data_addr_ok3, data_data_ok3, mem_en3;
    logic [3:0]  data_wstrb3, mem_we3;
    logic [31:0] inst_addr3, data_addr3, data_wdata3, cpu_rdata3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;

    sram_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk(clk), .rst(rst1),
        .inst_req(inst_req1), .inst_addr(inst_addr1),
        .inst_addr_ok(inst_addr_ok1), .inst_data_ok(inst_data_ok1),
        .data_req(data_req1), .data_wr(data_wr1), .data_wstrb(data_wstrb1),
        .data_addr(data_addr1), .data_wdata(data_wdata1),
        .data_addr_ok(data_addr_ok1), .data_data_ok(data_data_ok1),
        .cpu_rdata(cpu_rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    sram_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) dut3 (
        .clk(clk), .rst(rst3),
        .inst_req(inst_req3), .inst_addr(inst_addr3),
        .inst_addr_ok(inst_addr_ok3), .inst_data_ok(inst_data_ok3),
        .data_req(data_req3), .data_wr(data_wr3), .data_wstrb(data_wstrb3),
        .data_addr(data_addr3), .data_wdata(data_wdata3),
        .data_addr_ok(data_addr_ok3), .data_data_ok(data_data_ok3),
        .cpu_rdata(cpu_rdata3), .mem_en(mem_en3), .mem_we(mem_we3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // SRAM model for dut1: unwritten words read as 0xC0DE0000 | word index.
    logic [31:0]  mem [0:255];
    logic [255:0] written = '0;
    logic [31:0]  cur_word;
    always @(posedge clk) begin
        if (mem_en1) begin
            cur_word = written[mem_addr1[9:2]] ? mem[mem_addr1[9:2]]
                                               : (32'hC0DE0000 | 32'(mem_addr1[9:2]));
            mem_rdata1 <= cur_word;
            if (mem_we1 != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we1[b]) cur_word[8*b +: 8] = mem_wdata1[8*b +: 8];
                end
                mem[mem_addr1[9:2]]     <= cur_word;
                written[mem_addr1[9:2]] <= 1'b1;
            end
        end
    end

    // SRAM model for dut3: read data is a function of the address, 3 cycles late.
    logic [31:0] rd3_a, rd3_b;
    always @(posedge clk) begin
        rd3_a      <= mem_addr3 ^ 32'h5A5A5A5A;
        rd3_b      <= rd3_a;
        mem_rdata3 <= rd3_b;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       ireq, dreq, dwr;
        logic [3:0] wstrb;
        logic       e_iaok, e_daok, e_en;
        logic [3:0] e_we;
        logic       e_idok, e_ddok;
    } vec_t;

    vec_t tbl [12];

    task automatic idle1();
        inst_req1 = 1'b0; data_req1 = 1'b0; data_wr1 = 1'b0; data_wstrb1 = 4'b0000;
    endtask

    initial begin
        // Hand-computed arbitration table for STARVE_MAX=3, MEM_LAT=1
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

        rst1 = 1'b1; rst3 = 1'b1;
        idle1();
        inst_addr1 = 32'h0; data_addr1 = 32'h0; data_wdata1 = 32'h0;
        inst_req3 = 1'b0; data_req3 = 1'b0; data_wr3 = 1'b0; data_wstrb3 = 4'b0000;
        inst_addr3 = 32'h0; data_addr3 = 32'h0; data_wdata3 = 32'h0;

        // Reset state: requests present but everything held low
        @(negedge clk);
        inst_req1 = 1'b1; data_req1 = 1'b1; data_wr1 = 1'b1; data_wstrb1 = 4'b1111;
        #1;
        chk("rst_mem_en", 32'(mem_en1), 32'h0);
        chk("rst_mem_we", 32'(mem_we1), 32'h0);
        chk("rst_iaok", 32'(inst_addr_ok1), 32'h0);
        chk("rst_daok", 32'(data_addr_ok1), 32'h0);
        chk("rst_dok", 32'({inst_data_ok1, data_data_ok1}), 32'h0);
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;
        idle1();

        // Table-driven arbitration vectors
        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            inst_req1 = tbl[r].ireq; data_req1 = tbl[r].dreq;
            data_wr1 = tbl[r].dwr; data_wstrb1 = tbl[r].wstrb;
            inst_addr1 = 32'h1C000000 + 32'(r * 4);
            data_addr1 = 32'h00000200 + 32'(r * 4);
            data_wdata1 = 32'hDEAD0000 + 32'(r);
            #1;
            chk($sformatf("tbl%0d_iaok", r), 32'(inst_addr_ok1), 32'(tbl[r].e_iaok));
            chk($sformatf("tbl%0d_daok", r), 32'(data_addr_ok1), 32'(tbl[r].e_daok));
            chk($sformatf("tbl%0d_en", r), 32'(mem_en1), 32'(tbl[r].e_en));
            chk($sformatf("tbl%0d_we", r), 32'(mem_we1), 32'(tbl[r].e_we));
            chk($sformatf("tbl%0d_idok", r), 32'(inst_data_ok1), 32'(tbl[r].e_idok));
            chk($sformatf("tbl%0d_ddok", r), 32'(data_data_ok1), 32'(tbl[r].e_ddok));
            if (tbl[r].e_en)
                chk($sformatf("tbl%0d_addr", r), mem_addr1,
                    tbl[r].e_daok ? data_addr1 : inst_addr1);
            if (tbl[r].e_we != 4'b0000)
                chk($sformatf("tbl%0d_wdata", r), mem_wdata1, 32'hDEAD0000 + 32'(r));
        end

        // Both requests held: D,D,D,I,D,D,D,I
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            inst_req1 = 1'b1; data_req1 = 1'b1; data_wr1 = 1'b0;
            #1;
            chk($sformatf("fair%0d_daok", k), 32'(data_addr_ok1), 32'((k % 4) != 3));
            chk($sformatf("fair%0d_iaok", k), 32'(inst_addr_ok1), 32'((k % 4) == 3));
        end
        @(negedge clk); idle1();

        // Streaming fetch from 0x1c000000
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            inst_req1 = (i < 8);
            inst_addr1 = 32'h1C000000 + 32'(i * 4);
            #1;
            if (i < 8) chk($sformatf("fetch%0d_iaok", i), 32'(inst_addr_ok1), 32'h1);
            chk($sformatf("fetch%0d_idok", i), 32'(inst_data_ok1), 32'(i > 0));
            if (i > 0)
                chk($sformatf("fetch%0d_rdata", i), cpu_rdata1, 32'hC0DE0000 + 32'(i - 1));
        end

        // Partial store over a full store, then load back
        @(negedge clk);
        data_req1 = 1'b1; data_wr1 = 1'b1; data_wstrb1 = 4'b1111;
        data_addr1 = 32'h100; data_wdata1 = 32'h11111111;
        #1;
        chk("st1_daok", 32'(data_addr_ok1), 32'h1);
        chk("st1_we", 32'(mem_we1), 32'hF);
        @(negedge clk);
        data_wstrb1 = 4'b0011; data_wdata1 = 32'hAABBCCDD;
        #1;
        chk("st2_we", 32'(mem_we1), 32'h3);
        chk("st1_ddok", 32'(data_data_ok1), 32'h1);
        @(negedge clk);
        data_wr1 = 1'b0; data_wstrb1 = 4'b0000;
        #1;
        chk("ld_we", 32'(mem_we1), 32'h0);
        chk("st2_ddok", 32'(data_data_ok1), 32'h1);
        @(negedge clk); idle1(); #1;
        chk("ld_ddok", 32'(data_data_ok1), 32'h1);
        chk("ld_rdata", cpu_rdata1, 32'h1111CCDD);
        @(negedge clk); #1;
        chk("ld_after_ddok", 32'(data_data_ok1), 32'h0);

        // Data-only burst keeps the starvation count at zero
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            data_req1 = 1'b1; data_wr1 = 1'b0; data_addr1 = 32'h140 + 32'(k * 4);
            inst_req1 = (k >= 5);
            #1;
            chk($sformatf("burst%0d_daok", k), 32'(data_addr_ok1), 32'(k != 8));
            chk($sformatf("burst%0d_iaok", k), 32'(inst_addr_ok1), 32'(k == 8));
        end
        @(negedge clk); idle1(); #1;
        chk("quiet0_en", 32'(mem_en1), 32'h0);
        chk("quiet0_idok", 32'(inst_data_ok1), 32'h1);
        @(negedge clk); #1;
        chk("quiet1_en", 32'(mem_en1), 32'h0);
        chk("quiet1_dok", 32'({inst_data_ok1, data_data_ok1}), 32'h0);

        // MEM_LAT=3: alternating grants return 3 cycles later to the right port
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            inst_req3 = (c < 4) && (c % 2 == 0);
            data_req3 = (c < 4) && (c % 2 == 1);
            inst_addr3 = 32'h1C000000 + 32'(c * 4);
            data_addr3 = 32'h00000300 + 32'(c * 4);
            #1;
            chk($sformatf("lat3_%0d_en", c), 32'(mem_en3), 32'(c < 4));
            chk($sformatf("lat3_%0d_idok", c), 32'(inst_data_ok3),
                32'((c >= 3) && (c < 7) && ((c - 3) % 2 == 0)));
            chk($sformatf("lat3_%0d_ddok", c), 32'(data_data_ok3),
                32'((c >= 3) && (c < 7) && ((c - 3) % 2 == 1)));
            if (c >= 3 && c < 7)
                chk($sformatf("lat3_%0d_rdata", c), cpu_rdata3,
                    (((c - 3) % 2 == 0) ? (32'h1C000000 + 32'((c - 3) * 4))
                                        : (32'h00000300 + 32'((c - 3) * 4))) ^ 32'h5A5A5A5A);
        end

        // Reset with two requests in flight drops them
        @(negedge clk); inst_req3 = 1'b1; inst_addr3 = 32'h1C000040;
        @(negedge clk); inst_req3 = 1'b0; data_req3 = 1'b1;
        @(negedge clk); inst_req3 = 1'b1; rst3 = 1'b1;
        #1;
        chk("midrst_en", 32'(mem_en3), 32'h0);
        chk("midrst_aok", 32'({inst_addr_ok3, data_addr_ok3}), 32'h0);
        chk("midrst_dok", 32'({inst_data_ok3, data_data_ok3}), 32'h0);
        @(negedge clk); rst3 = 1'b0; inst_req3 = 1'b0; data_req3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("postrst%0d_dok", k), 32'({inst_data_ok3, data_data_ok3}), 32'h0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
